// File: rtl/pix_pkg.sv
// Pixel types shared by the HSV converter arbiter.
// Channel layouts, grant encoding and the converter byte repack.
package pix_pkg;

    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int ID_W  = 1;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        logic [CH_W-1:0] h;
        logic [CH_W-1:0] s;
        logic [CH_W-1:0] v;
    } hsv_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // Native byte order of the shared converter's result bus.
    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] g;
    } rbg_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        rgb_t            rgb;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_0    = 2'd1,
        GNT_1    = 2'd2
    } gnt_e;

    function automatic rgb_t rbg_to_rgb(input pix_t raw);
        rbg_t src;
        rgb_t dst;
        src   = rbg_t'(raw);
        dst.r = src.r;
        dst.g = src.g;
        dst.b = src.b;
        return dst;
    endfunction

endpackage

// File: rtl/pix_sync_fifo.sv
// Single-clock result FIFO with occupancy count.
// The head output holds the last popped word while the FIFO is empty.
module pix_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] last_q;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_C);
    assign rd_en = pop_i & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push_i & (~full | rd_en);

    always_comb begin
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign valid_o = ~empty;
    assign rdata_o = empty ? last_q : mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/hsv_conv_arbiter.sv
// Two-requester round-robin front end for one pipelined HSV->RGB converter.
// Results are tracked through the converter latency and queued with their requester id.
module hsv_conv_arbiter
    import pix_pkg::*;
#(
    parameter int CONV_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter bit REORDER    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [PIX_W-1:0] req0_hsv,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [PIX_W-1:0] req1_hsv,
    output logic             req1_ready,
    output logic [PIX_W-1:0] conv_hsv,
    input  logic [PIX_W-1:0] conv_rgb,
    output logic             rsp_valid,
    output logic [PIX_W-1:0] rsp_rgb,
    output logic [ID_W-1:0]  rsp_id,
    input  logic             rsp_ready
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int PID_W = CONV_LAT * ID_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    gnt_e             gnt;
    logic             rr_q;
    logic             rr_d;
    logic [CW-1:0]    infl_q;
    logic [CW-1:0]    infl_d;
    logic [CW-1:0]    fifo_cnt;
    logic [CW:0]      used;
    logic             credit_ok;
    logic             issue0;
    logic             issue1;
    logic             issue;
    logic [ID_W-1:0]  iss_id;
    logic [CONV_LAT-1:0] pv_q;
    logic [CONV_LAT-1:0] pv_d;
    logic [PID_W-1:0] pid_q;
    logic [PID_W-1:0] pid_d;
    logic             push;
    logic             pop;
    rgb_t             push_rgb;
    rsp_t             push_word;
    rsp_t             head;
    logic             head_vld;

    // Grant is decided from current requests and registered priority only.
    always_comb begin
        gnt = GNT_NONE;
        unique case ({req1_valid, req0_valid})
            2'b01:   gnt = GNT_0;
            2'b10:   gnt = GNT_1;
            2'b11:   gnt = rr_q ? GNT_1 : GNT_0;
            default: gnt = GNT_NONE;
        endcase
    end

    // Credit counts both queued results and results still inside the converter.
    assign used      = {1'b0, fifo_cnt} + {1'b0, infl_q};
    assign credit_ok = (used < DEPTH_C);

    assign req0_ready = reset_n & credit_ok & (gnt == GNT_0);
    assign req1_ready = reset_n & credit_ok & (gnt == GNT_1);

    assign issue0 = req0_valid & req0_ready;
    assign issue1 = req1_valid & req1_ready;
    assign issue  = issue0 | issue1;
    assign iss_id = ID_W'(issue1);

    always_comb begin
        conv_hsv = '0;
        if (reset_n) begin
            unique case (gnt)
                GNT_0:   conv_hsv = req0_hsv;
                GNT_1:   conv_hsv = req1_hsv;
                default: conv_hsv = '0;
            endcase
        end
    end

    assign push = pv_q[CONV_LAT-1];
    assign pop  = head_vld & rsp_ready;

    always_comb begin
        rr_d   = issue ? issue0 : rr_q;
        infl_d = infl_q + CW'(issue) - CW'(push);
        pv_d   = (pv_q << 1) | CONV_LAT'(issue);
        pid_d  = (pid_q << ID_W) | PID_W'(iss_id);
    end

    always_comb begin
        push_rgb = REORDER ? rbg_to_rgb(conv_rgb) : rgb_t'(conv_rgb);
        push_word.id  = pid_q[PID_W-1 -: ID_W];
        push_word.rgb = push_rgb;
    end

    // Clearing the tag pipe on reset discards whatever the converter still holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q   <= 1'b0;
            infl_q <= '0;
            pv_q   <= '0;
            pid_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            infl_q <= infl_d;
            pv_q   <= pv_d;
            pid_q  <= pid_d;
        end
    end

    pix_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .valid_o (head_vld),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = head_vld;
    assign rsp_rgb   = head.rgb;
    assign rsp_id    = head.id;

endmodule

// File: tb/tb_hsv_conv_arbiter.sv
// Bench for hsv_conv_arbiter: table vectors, directed corner sequences, random scoreboard.
// A stub converter registers a byte-scramble of conv_hsv in {R,B,G} order.
module tb_hsv_conv_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid;
    logic [23:0] req0_hsv;
    logic        req0_ready;
    logic        req1_valid;
    logic [23:0] req1_hsv;
    logic        req1_ready;
    logic [23:0] conv_hsv;
    logic [23:0] conv_rgb;
    logic        rsp_valid;
    logic [23:0] rsp_rgb;
    logic        rsp_id;
    logic        rsp_ready;

    hsv_conv_arbiter #(
        .CONV_LAT   (1),
        .FIFO_DEPTH (4),
        .REORDER    (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_hsv   (req0_hsv),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_hsv   (req1_hsv),
        .req1_ready (req1_ready),
        .conv_hsv   (conv_hsv),
        .conv_rgb   (conv_rgb),
        .rsp_valid  (rsp_valid),
        .rsp_rgb    (rsp_rgb),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] conv_f(input logic [23:0] h);
        logic [7:0] r, g, b;
        r = h[23:16] ^ 8'h5A;
        g = h[15:8] ^ h[7:0];
        b = h[7:0] + 8'd3;
        return {r, b, g};
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [23:0] h);
        logic [7:0] r, g, b;
        r = h[23:16] ^ 8'h5A;
        g = h[15:8] ^ h[7:0];
        b = h[7:0] + 8'd3;
        return {r, g, b};
    endfunction

    always @(posedge clk) conv_rgb <= conv_f(conv_hsv);

    typedef struct packed {
        logic        id;
        logic [23:0] rgb;
    } ent_t;

    typedef struct {
        bit          id;
        logic [23:0] hsv;
        logic [23:0] rgb;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        sb[$];
    bit          ilog[$];
    bit          iss0, iss1;
    bit          rr_m;
    logic [23:0] last_m;
    bit          prev_v, prev_r, prev_id;
    logic [23:0] prev_rgb;
    int          nacc, nret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    task automatic model_reset();
        sb.delete();
        rr_m   = 1'b0;
        last_m = '0;
        prev_v = 1'b0;
        prev_r = 1'b0;
    endtask

    task automatic mon();
        int   g;
        bit   cr;
        ent_t e;
        iss0 = 1'b0;
        iss1 = 1'b0;
        cr = (sb.size() < 4);
        g = 0;
        if (req0_valid && req1_valid) g = rr_m ? 2 : 1;
        else if (req0_valid) g = 1;
        else if (req1_valid) g = 2;
        chk("ready0", 32'(req0_ready), 32'(cr && g == 1));
        chk("ready1", 32'(req1_ready), 32'(cr && g == 2));
        if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rgb", 32'(rsp_rgb), 32'(prev_rgb));
            chk("hold_id", 32'(rsp_id), 32'(prev_id));
        end
        if (!rsp_valid) chk("empty_rgb", 32'(rsp_rgb), 32'(last_m));
        if (rsp_valid && sb.size() == 0) begin
            fail("spurious_rsp");
        end else if (rsp_valid && rsp_ready) begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
            last_m = e.rgb;
            nret++;
        end
        if (req0_valid && req0_ready) begin
            iss0 = 1'b1;
            chk("conv_hsv0", 32'(conv_hsv), 32'(req0_hsv));
            e.id = 1'b0;
            e.rgb = exp_rgb(req0_hsv);
            sb.push_back(e);
            ilog.push_back(1'b0);
            rr_m = 1'b1;
            nacc++;
        end
        if (req1_valid && req1_ready) begin
            iss1 = 1'b1;
            chk("conv_hsv1", 32'(conv_hsv), 32'(req1_hsv));
            e.id = 1'b1;
            e.rgb = exp_rgb(req1_hsv);
            sb.push_back(e);
            ilog.push_back(1'b1);
            rr_m = 1'b0;
            nacc++;
        end
        prev_v   = rsp_valid;
        prev_r   = rsp_ready;
        prev_rgb = rsp_rgb;
        prev_id  = rsp_id;
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            sample();
            adv();
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic send_check(input vec_t v);
        bit done;
        done = 1'b0;
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1;
            req1_hsv   = v.hsv;
        end else begin
            req0_valid = 1'b1;
            req0_hsv   = v.hsv;
        end
        for (int w = 0; w < 8 && !done; w++) begin
            sample();
            done = v.id ? iss1 : iss0;
            adv();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!done) fail("send_timeout");
        sample();
        chk("lat_early", 32'(rsp_valid), 32'd0);
        adv();
        sample();
        chk("lat_valid", 32'(rsp_valid), 32'd1);
        chk("lat_id", 32'(rsp_id), 32'(v.id));
        chk("lat_rgb", 32'(rsp_rgb), 32'(v.rgb));
        adv();
        sample();
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rgb", 32'(rsp_rgb), 32'(v.rgb));
        adv();
    endtask

    vec_t vt[5];

    initial begin
        int n, n2, s0, s1, cyc;
        logic [23:0] cap_rgb;
        vt[0] = '{id: 1'b0, hsv: 24'h00FFFF, rgb: 24'h5A0002};
        vt[1] = '{id: 1'b1, hsv: 24'h123456, rgb: 24'h486259};
        vt[2] = '{id: 1'b0, hsv: 24'hFF0000, rgb: 24'hA50003};
        vt[3] = '{id: 1'b1, hsv: 24'hA5A5FD, rgb: 24'hFF5800};
        vt[4] = '{id: 1'b0, hsv: 24'h5A0F0F, rgb: 24'h000012};

        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_hsv   = '0;
        req1_hsv   = '0;
        rsp_ready  = 1'b0;
        nacc = 0;
        nret = 0;
        model_reset();
        #12;
        req0_valid = 1'b1;
        req0_hsv   = 24'h123456;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rgb", 32'(rsp_rgb), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_conv", 32'(conv_hsv), 32'd0);
        req0_valid = 1'b0;
        adv();
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) send_check(vt[i]);

        // both requesters continuously valid, 8 pixels each
        ilog.delete();
        s0 = 0;
        s1 = 0;
        cyc = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && (s0 < 8 || s1 < 8); c++) begin
            req0_valid = (s0 < 8);
            req0_hsv   = {8'(s0 * 17), 8'hA0, 8'(s0)};
            req1_valid = (s1 < 8);
            req1_hsv   = {8'(s1 * 29), 8'h0C, 8'(s1 + 100)};
            sample();
            if (iss0) s0++;
            if (iss1) s1++;
            cyc++;
            adv();
        end
        chk("alt_count", 32'(ilog.size()), 32'd16);
        chk("alt_cycles", 32'(cyc), 32'd16);
        for (int i = 1; i < ilog.size(); i++) begin
            chk("alt_order", 32'(ilog[i]), 32'(!ilog[i-1]));
        end
        drain();

        // backpressure: fill, hold, release
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        cap_rgb = '0;
        for (int c = 0; c < 14; c++) begin
            req0_hsv = 24'($urandom);
            req1_hsv = 24'($urandom);
            sample();
            n += int'(iss0) + int'(iss1);
            if (c == 4) cap_rgb = rsp_rgb;
            if (c == 13) begin
                chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("bp_hold_rgb", 32'(rsp_rgb), 32'(cap_rgb));
            end
            adv();
        end
        chk("bp_issues", 32'(n), 32'd4);
        rsp_ready = 1'b1;
        n2 = 0;
        for (int c = 0; c < 12; c++) begin
            req0_hsv = 24'($urandom);
            req1_hsv = 24'($urandom);
            sample();
            n2 += int'(iss0) + int'(iss1);
            adv();
        end
        chk("full_flow_issues", 32'(n2), 32'd11);
        drain();

        // reset with pixels in flight
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            req0_hsv = {8'(c + 1), 8'h33, 8'h44};
            sample();
            n += int'(iss0);
            adv();
        end
        chk("mid_pre_issues", 32'(n), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_ready0", 32'(req0_ready), 32'd0);
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rgb", 32'(rsp_rgb), 32'd0);
        chk("mid_id", 32'(rsp_id), 32'd0);
        chk("mid_conv", 32'(conv_hsv), 32'd0);
        model_reset();
        adv();
        req0_valid = 1'b0;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("mid_no_stale", 32'(rsp_valid), 32'd0);
            adv();
        end
        send_check(vt[3]);
        send_check(vt[0]);

        // random traffic
        nacc = 0;
        nret = 0;
        for (int c = 0; c < 10000; c++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_hsv   = 24'($urandom);
            req1_hsv   = 24'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 7);
            sample();
            adv();
        end
        drain();
        chk("rand_acc_ret", 32'(nret), 32'(nacc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
